// File: rtl/bms_pkg.sv
// Shared battery-management types: session states, fault codes, thresholds.
package bms_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DEBOUNCE = 3'd1,
    ST_FAST     = 3'd2,
    ST_SLOW     = 3'd3,
    ST_PAUSE    = 3'd4,
    ST_DONE     = 3'd5,
    ST_FAULT    = 3'd6
  } state_e;

  localparam logic [1:0] FC_NONE       = 2'd0;
  localparam logic [1:0] FC_OVERCHARGE = 2'd1;
  localparam logic [1:0] FC_MOISTURE   = 2'd2;
  localparam logic [1:0] FC_TIMEOUT    = 2'd3;

  localparam int FAST_LIMIT_DEF  = 80;
  localparam int FULL_LEVEL_DEF  = 100;
  localparam int TEMP_HOT_DEF    = 45;
  localparam int TEMP_RESUME_DEF = 40;

  function automatic state_e level_state(
    input logic [7:0] lvl,
    input logic [7:0] fast_lim,
    input logic [7:0] full
  );
    if (lvl >= full)
      return ST_DONE;
    if (lvl < fast_lim)
      return ST_FAST;
    return ST_SLOW;
  endfunction

endpackage

// File: rtl/charge_debounce.sv
// Plug debounce: counts consecutive plugged cycles while enabled.
module charge_debounce #(
  parameter int CYC = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic plugged,
  output logic stable
);

  localparam int W = (CYC > 1) ? $clog2(CYC) : 1;
  localparam logic [W-1:0] LAST = W'(CYC - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (!en || !plugged)
      cnt <= '0;
    else if (cnt != LAST)
      cnt <= cnt + 1'b1;
  end

  assign stable = plugged && (cnt == LAST);

endmodule

// File: rtl/charge_sequencer.sv
// Charge-session FSM with thermal pause, timeout and fault latch.
// Optional soft-start on FAST entry: define CHARGE_SOFTSTART_EN.
module charge_sequencer
  import bms_pkg::*;
#(
  parameter int DEBOUNCE_CYC  = 16,
  parameter int FAST_LIMIT    = FAST_LIMIT_DEF,
  parameter int FULL_LEVEL    = FULL_LEVEL_DEF,
  parameter int TEMP_HOT      = TEMP_HOT_DEF,
  parameter int TEMP_RESUME   = TEMP_RESUME_DEF,
  parameter int TIMEOUT_CYC   = 4096
`ifdef CHARGE_SOFTSTART_EN
  ,
  parameter int SOFTSTART_CYC = 8
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       charger_plugged,
  input  logic [7:0] battery_level,
  input  logic [6:0] temperature,
  input  logic       moisture_ok,
  input  logic       overcharge_alert,
  output logic       charge_en,
  output logic       fast_mode,
  output logic       cooling_fan,
  output logic [2:0] phase,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic       session_done
);

  localparam logic [7:0] FAST_L = 8'(FAST_LIMIT);
  localparam logic [7:0] FULL_L = 8'(FULL_LEVEL);
  localparam logic [6:0] T_HOT  = 7'(TEMP_HOT);
  localparam logic [6:0] T_RES  = 7'(TEMP_RESUME);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYC);

  state_e state, nxt;
  logic [TW-1:0] tcnt;
  logic [7:0] lvl;
  logic [1:0] cause;
  logic charging, to_hit, hot, cool;
  logic stable, cause_clear, fast_nxt;

  charge_debounce #(.CYC(DEBOUNCE_CYC)) u_deb (
    .clk     (clk),
    .reset   (reset),
    .en      (state == ST_IDLE || state == ST_DEBOUNCE),
    .plugged (charger_plugged),
    .stable  (stable)
  );

  assign lvl      = (battery_level > FULL_L) ? FULL_L : battery_level;
  assign charging = (state == ST_FAST) || (state == ST_SLOW);
  assign to_hit   = charging && (tcnt == TO_LAST);
  assign hot      = temperature > T_HOT;
  assign cool     = temperature <= T_RES;
  assign phase    = state;

  always_comb begin
    cause = FC_NONE;
    if (overcharge_alert)
      cause = FC_OVERCHARGE;
    else if (!moisture_ok)
      cause = FC_MOISTURE;
    else if (to_hit)
      cause = FC_TIMEOUT;
  end

  // Only the latched cause has to clear; a timeout needs unplug alone.
  always_comb begin
    cause_clear = 1'b1;
    unique case (fault_code)
      FC_OVERCHARGE: cause_clear = !overcharge_alert;
      FC_MOISTURE:   cause_clear = moisture_ok;
      default:       cause_clear = 1'b1;
    endcase
  end

  always_comb begin
    nxt = state;
    unique case (state)
      ST_IDLE:
        if (charger_plugged) nxt = ST_DEBOUNCE;
      ST_DEBOUNCE:
        if (!charger_plugged) nxt = ST_IDLE;
        else if (stable) nxt = level_state(lvl, FAST_L, FULL_L);
      ST_FAST:
        if (!charger_plugged) nxt = ST_IDLE;
        else if (hot) nxt = ST_PAUSE;
        else if (lvl >= FAST_L) nxt = ST_SLOW;
      ST_SLOW:
        if (!charger_plugged) nxt = ST_IDLE;
        else if (hot) nxt = ST_PAUSE;
        else if (lvl >= FULL_L) nxt = ST_DONE;
      ST_PAUSE:
        if (!charger_plugged) nxt = ST_IDLE;
        else if (cool) nxt = level_state(lvl, FAST_L, FULL_L);
      ST_DONE:
        if (!charger_plugged) nxt = ST_IDLE;
      ST_FAULT:
        if (!charger_plugged && cause_clear) nxt = ST_IDLE;
      default:
        nxt = ST_IDLE;
    endcase
    if (state != ST_IDLE && state != ST_FAULT && cause != FC_NONE)
      nxt = ST_FAULT;
  end

`ifdef CHARGE_SOFTSTART_EN
  localparam int SW = $clog2(SOFTSTART_CYC + 2);
  localparam logic [SW-1:0] SS_CYC = SW'(SOFTSTART_CYC);
  localparam logic [SW-1:0] SS_LIM = SW'(SOFTSTART_CYC + 1);

  logic [SW-1:0] ss_cnt, ss_idx;

  // ss_idx is the 1-based FAST cycle about to start.
  assign ss_idx   = (state == ST_FAST) ? ss_cnt + 1'b1 : SW'(1);
  assign fast_nxt = (nxt == ST_FAST) && (ss_idx > SS_CYC);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      ss_cnt <= '0;
    else if (nxt != ST_FAST)
      ss_cnt <= '0;
    else
      ss_cnt <= (ss_idx > SS_LIM) ? SS_LIM : ss_idx;
  end
`else
  assign fast_nxt = (nxt == ST_FAST);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      tcnt         <= '0;
      charge_en    <= 1'b0;
      fast_mode    <= 1'b0;
      cooling_fan  <= 1'b0;
      fault        <= 1'b0;
      fault_code   <= FC_NONE;
      session_done <= 1'b0;
    end else begin
      state <= nxt;
      if (state == ST_IDLE)
        tcnt <= '0;
      else if (charging && tcnt != TO_MAX)
        tcnt <= tcnt + 1'b1;
      charge_en    <= (nxt == ST_FAST) || (nxt == ST_SLOW);
      fast_mode    <= fast_nxt;
      cooling_fan  <= (nxt == ST_PAUSE) ||
                      ((nxt == ST_FAST) && (temperature > T_RES));
      fault        <= (nxt == ST_FAULT);
      fault_code   <= (nxt != ST_FAULT) ? FC_NONE :
                      (state == ST_FAULT) ? fault_code : cause;
      session_done <= (nxt == ST_DONE) && (state != ST_DONE);
    end
  end

endmodule

// File: tb/tb_charge_sequencer.sv
// Directed bench for charge_sequencer (TIMEOUT_CYC overridden to 64).
module tb_charge_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       charger_plugged;
  logic [7:0] battery_level;
  logic [6:0] temperature;
  logic       moisture_ok;
  logic       overcharge_alert;
  logic       charge_en;
  logic       fast_mode;
  logic       cooling_fan;
  logic [2:0] phase;
  logic       fault;
  logic [1:0] fault_code;
  logic       session_done;

  int errors = 0;
  int checks = 0;

`ifdef CHARGE_SOFTSTART_EN
  localparam logic SS = 1'b1;
`else
  localparam logic SS = 1'b0;
`endif

  charge_sequencer #(.TIMEOUT_CYC(64)) dut (
    .clk              (clk),
    .reset            (reset),
    .charger_plugged  (charger_plugged),
    .battery_level    (battery_level),
    .temperature      (temperature),
    .moisture_ok      (moisture_ok),
    .overcharge_alert (overcharge_alert),
    .charge_en        (charge_en),
    .fast_mode        (fast_mode),
    .cooling_fan      (cooling_fan),
    .phase            (phase),
    .fault            (fault),
    .fault_code       (fault_code),
    .session_done     (session_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_o(input string tag, input int ph, input int ce,
                       input int fm, input int fan);
    chk({tag, ".phase"}, 32'(phase), ph);
    chk({tag, ".ce"}, 32'(charge_en), ce);
    chk({tag, ".fast"}, 32'(fast_mode), fm);
    chk({tag, ".fan"}, 32'(cooling_fan), fan);
  endtask

  task automatic chk_f(input string tag, input int f, input int code);
    chk({tag, ".fault"}, 32'(fault), f);
    chk({tag, ".code"}, 32'(fault_code), code);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1'b1;
    charger_plugged = 1'b0;
    battery_level = 8'd0;
    temperature = 7'd30;
    moisture_ok = 1'b1;
    overcharge_alert = 1'b0;
    #12;
    chk_o("rst", 0, 0, 0, 0);
    chk_f("rst", 0, 0);
    chk("rst.done", 32'(session_done), 0);
    @(negedge clk);
    reset = 1'b0;

    // Normal session: debounce, FAST, SLOW, DONE
    charger_plugged = 1'b1;
    battery_level = 8'd50;
    tick(15);
    chk_o("deb15", 1, 0, 0, 0);
    tick();
    chk_o("fast", 2, 1, int'(!SS), 0);
    battery_level = 8'd80;
    tick();
    chk_o("slow", 3, 1, 0, 0);
    battery_level = 8'd100;
    tick();
    chk_o("done", 5, 0, 0, 0);
    chk("done.pulse", 32'(session_done), 1);
    tick();
    chk("done.pulse2", 32'(session_done), 0);
    chk("done.hold", 32'(phase), 5);
    charger_plugged = 1'b0;
    tick();
    chk_o("unplug", 0, 0, 0, 0);

    // Plug glitch, then a clean plug
    charger_plugged = 1'b1;
    battery_level = 8'd50;
    tick(5);
    chk_o("glitch", 1, 0, 0, 0);
    charger_plugged = 1'b0;
    tick();
    chk_o("glitch.idle", 0, 0, 0, 0);
    charger_plugged = 1'b1;
    tick(15);
    chk_o("replug15", 1, 0, 0, 0);
    tick();
    chk_o("replug", 2, 1, int'(!SS), 0);

    // Thermal hysteresis
    temperature = 7'd42;
    tick();
    chk_o("fast42", 2, 1, int'(!SS), 1);
    temperature = 7'd46;
    tick();
    chk_o("pause46", 4, 0, 0, 1);
    temperature = 7'd42;
    tick();
    chk_o("pause42", 4, 0, 0, 1);
    temperature = 7'd40;
    tick();
    chk_o("resume40", 2, 1, int'(!SS), 0);

    // Overcharge and moisture together in SLOW
    battery_level = 8'd80;
    tick();
    chk_o("slow2", 3, 1, 0, 0);
    overcharge_alert = 1'b1;
    moisture_ok = 1'b0;
    tick();
    chk_o("oc", 6, 0, 0, 0);
    chk_f("oc", 1, 1);
    charger_plugged = 1'b0;
    tick();
    chk("oc.latched", 32'(phase), 6);
    chk_f("oc.latched", 1, 1);
    overcharge_alert = 1'b0;
    moisture_ok = 1'b1;
    tick();
    chk_o("oc.clear", 0, 0, 0, 0);
    chk_f("oc.clear", 0, 0);

    // Over-range level straight to DONE
    charger_plugged = 1'b1;
    battery_level = 8'd120;
    tick(16);
    chk_o("lvl120", 5, 0, 0, 0);
    chk("lvl120.pulse", 32'(session_done), 1);
    charger_plugged = 1'b0;
    tick();
    chk("lvl120.idle", 32'(phase), 0);

    // Unplug and moisture fault together: fault wins
    charger_plugged = 1'b1;
    battery_level = 8'd50;
    tick(16);
    chk("mo.fast", 32'(phase), 2);
    charger_plugged = 1'b0;
    moisture_ok = 1'b0;
    tick();
    chk_o("mo", 6, 0, 0, 0);
    chk_f("mo", 1, 2);
    moisture_ok = 1'b1;
    tick();
    chk_f("mo.clear", 0, 0);
    chk("mo.idle", 32'(phase), 0);

    // Timeout: 64 FAST cycles with a 10-cycle pause
    charger_plugged = 1'b1;
    battery_level = 8'd30;
    temperature = 7'd30;
    tick(16);
    chk("to.c1", 32'(phase), 2);
    tick(29);
    chk_o("to.c30", 2, 1, 1, 0);
    temperature = 7'd46;
    tick();
    chk("to.pause", 32'(phase), 4);
    tick(9);
    chk("to.pause10", 32'(phase), 4);
    temperature = 7'd30;
    tick();
    chk("to.c31", 32'(phase), 2);
    tick(33);
    chk_o("to.c64", 2, 1, 1, 0);
    chk_f("to.c64", 0, 0);
    tick();
    chk_o("to.fault", 6, 0, 0, 0);
    chk_f("to.fault", 1, 3);
    charger_plugged = 1'b0;
    tick();
    chk_f("to.clear", 0, 0);
    chk("to.idle", 32'(phase), 0);

    // Asynchronous reset mid-FAST
    charger_plugged = 1'b1;
    battery_level = 8'd50;
    temperature = 7'd42;
    tick(16);
    chk_o("pre_rst", 2, 1, int'(!SS), 1);
    #2;
    reset = 1'b1;
    #1;
    chk_o("async_rst", 0, 0, 0, 0);
    chk_f("async_rst", 0, 0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("post_rst", 32'(phase), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
